// File: rtl/lif_scheduler_if.sv
// Host-side bus of the LIF scheduler: configuration writes, state readback,
// timestep control and the spike event stream.
interface lif_scheduler_if;
    logic       tick;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       thr_we;
    logic [7:0] thr_data;
    logic [1:0] rd_addr;
    logic [7:0] rd_state;
    logic       busy;
    logic       done;
    logic       ev_valid;
    logic [1:0] ev_addr;
    logic       ev_ready;
    logic       overrun;

    modport master (
        output tick, cfg_we, cfg_addr, cfg_data, thr_we, thr_data, rd_addr, ev_ready,
        input  rd_state, busy, done, ev_valid, ev_addr, overrun
    );

    modport slave (
        input  tick, cfg_we, cfg_addr, cfg_data, thr_we, thr_data, rd_addr, ev_ready,
        output rd_state, busy, done, ev_valid, ev_addr, overrun
    );
endinterface

// File: rtl/lif_scheduler.sv
// Time-multiplexed leaky integrate-and-fire scheduler: one shared update
// datapath walks four neurons per timestep, then drains spike events
// lowest index first through a valid/ready stream.
module lif_scheduler #(
    parameter int         N_NEURONS = 4,
    parameter logic [7:0] THR_RESET = 8'd200
) (
    input  logic             clk,
    input  logic             rst_n,
    lif_scheduler_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_EMIT, S_DONE} state_t;

    state_t                        st_q, st_d;
    logic [N_NEURONS-1:0][7:0]     mem_q;
    logic [N_NEURONS-1:0][7:0]     cur_q;
    logic [7:0]                    thr_q;
    logic [N_NEURONS-1:0]          pend_q, pend_d;
    logic [1:0]                    idx_q, idx_d;
    logic                          ovr_q;

    logic [7:0] s_old, c_old, leak, s_new;
    logic [8:0] sum;
    logic       spike;
    logic [1:0] first_c;
    logic       hs;

    // Shared LIF datapath: compare and integrate on the pre-update values.
    always_comb begin
        s_old = mem_q[idx_q];
        c_old = cur_q[idx_q];
        spike = (s_old >= thr_q);
        leak  = s_old - (s_old >> 3);
        sum   = {1'b0, c_old} + {1'b0, leak};
        if (spike)
            s_new = 8'd0;
        else if (sum[8])
            s_new = 8'hFF;
        else
            s_new = sum[7:0];
    end

    // Priority pick of the lowest pending neuron; defaults to 0 when empty.
    always_comb begin
        first_c = 2'd0;
        for (int i = N_NEURONS - 1; i >= 0; i--)
            if (pend_q[i]) first_c = 2'(i);
    end

    assign hs = (st_q == S_EMIT) && (|pend_q) && bus.ev_ready;

    // Next-state logic for the timestep sequencer and pending spike vector.
    always_comb begin
        st_d   = st_q;
        idx_d  = idx_q;
        pend_d = pend_q;
        case (st_q)
            S_IDLE: begin
                if (bus.tick) begin
                    st_d  = S_UPDATE;
                    idx_d = 2'd0;
                end
            end
            S_UPDATE: begin
                if (spike) pend_d[idx_q] = 1'b1;
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'(N_NEURONS - 1)) st_d = S_EMIT;
            end
            S_EMIT: begin
                if (hs) pend_d[first_c] = 1'b0;
                // Leave as soon as the last event is taken (or none existed).
                if (pend_d == '0) st_d = S_DONE;
            end
            S_DONE: st_d = S_IDLE;
            default: st_d = S_IDLE;
        endcase
    end

    // Control registers; a tick arriving while busy is dropped and flagged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q   <= S_IDLE;
            idx_q  <= 2'd0;
            pend_q <= '0;
            ovr_q  <= 1'b0;
            thr_q  <= THR_RESET;
        end else begin
            st_q   <= st_d;
            idx_q  <= idx_d;
            pend_q <= pend_d;
            ovr_q  <= bus.tick && (st_q != S_IDLE);
            if (bus.thr_we) thr_q <= bus.thr_data;
        end
    end

    // Per-neuron storage: host current writes and membrane updates.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q <= '0;
            cur_q <= '0;
        end else begin
            for (int n = 0; n < N_NEURONS; n++) begin
                if (bus.cfg_we && (bus.cfg_addr == 2'(n)))
                    cur_q[n] <= bus.cfg_data;
                if ((st_q == S_UPDATE) && (idx_q == 2'(n)))
                    mem_q[n] <= s_new;
            end
        end
    end

    assign bus.rd_state = mem_q[bus.rd_addr];
    assign bus.busy     = (st_q != S_IDLE);
    assign bus.done     = (st_q == S_DONE);
    assign bus.ev_valid = (st_q == S_EMIT) && (|pend_q);
    assign bus.ev_addr  = first_c;
    assign bus.overrun  = ovr_q;
endmodule

// File: tb/tb_lif_scheduler.sv
// Directed bench for lif_scheduler: reset, integration/saturation,
// idle timestep timing, event backpressure, overrun, mid-step writes and
// reset during event drain.
module tb_lif_scheduler;
    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    lif_scheduler_if bus();

    lif_scheduler #(.N_NEURONS(4), .THR_RESET(8'd200)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic write_cur(input logic [1:0] a, input logic [7:0] d);
        bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_data = d;
        step();
        bus.cfg_we = 1'b0;
    endtask

    // Raise tick for one cycle; returns in cycle T+1.
    task automatic do_tick();
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({bus.busy, bus.done, bus.ev_valid, bus.overrun} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 0000", {bus.busy, bus.done, bus.ev_valid, bus.overrun});
        end
        n_tests++;
        if (bus.ev_addr !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_ev_addr: got %0d want 0", bus.ev_addr);
        end
        for (int i = 0; i < 4; i++) begin
            bus.rd_addr = 2'(i);
            #1;
            n_tests++;
            if (bus.rd_state !== 8'd0) begin
                n_fail++;
                $display("FAIL reset_state%0d: got %0d want 0", i, bus.rd_state);
            end
        end
    endtask

    task automatic test_saturation();
        logic [7:0] exp_s [4] = '{8'd100, 8'd188, 8'd255, 8'd0};
        do_reset();
        bus.ev_ready = 1'b1;
        bus.rd_addr  = 2'd0;
        write_cur(2'd0, 8'd100);
        for (int k = 0; k < 4; k++) begin
            do_tick();          // T+1
            step(4);            // T+5 (EMIT)
            n_tests++;
            if (bus.ev_valid !== (k == 3) || (k == 3 && bus.ev_addr !== 2'd0)) begin
                n_fail++;
                $display("FAIL sat_event%0d: got v=%b a=%0d want v=%b a=0", k, bus.ev_valid, bus.ev_addr, k == 3);
            end
            step();             // T+6 (DONE)
            n_tests++;
            if (bus.done !== 1'b1) begin
                n_fail++;
                $display("FAIL sat_done%0d: got %b want 1", k, bus.done);
            end
            step();             // T+7 (IDLE)
            n_tests++;
            if (bus.rd_state !== exp_s[k] || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL sat_state%0d: got %0d busy=%b want %0d busy=0", k, bus.rd_state, bus.busy, exp_s[k]);
            end
        end
    endtask

    task automatic test_no_spike();
        logic [2:0] got, exp;
        do_reset();
        bus.ev_ready = 1'b1;
        do_tick();
        for (int c = 1; c <= 7; c++) begin
            got = {bus.busy, bus.done, bus.ev_valid};
            exp = {c <= 6, c == 6, 1'b0};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL idle_step_T+%0d: busy/done/ev_valid got %b want %b", c, got, exp);
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.ev_ready = 1'b0;
        write_cur(2'd1, 8'd250);
        write_cur(2'd3, 8'd250);
        do_tick();
        step(6);                // IDLE, states now 250
        bus.rd_addr = 2'd1;
        #1;
        n_tests++;
        if (bus.rd_state !== 8'd250) begin
            n_fail++;
            $display("FAIL bp_charge: got %0d want 250", bus.rd_state);
        end
        do_tick();
        step(4);                // T+5
        for (int c = 0; c < 6; c++) begin
            if (c == 5) begin
                bus.ev_ready = 1'b1;
                #1;
            end
            n_tests++;
            if (bus.ev_valid !== 1'b1 || bus.ev_addr !== 2'd1) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got v=%b a=%0d want v=1 a=1", c, bus.ev_valid, bus.ev_addr);
            end
            if (c < 5) step();
        end
        step();
        n_tests++;
        if (bus.ev_valid !== 1'b1 || bus.ev_addr !== 2'd3) begin
            n_fail++;
            $display("FAIL bp_second: got v=%b a=%0d want v=1 a=3", bus.ev_valid, bus.ev_addr);
        end
        step();
        n_tests++;
        if (bus.done !== 1'b1 || bus.ev_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_done: got done=%b v=%b want done=1 v=0", bus.done, bus.ev_valid);
        end
        step();
        bus.rd_addr = 2'd3;
        #1;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.rd_state !== 8'd0) begin
            n_fail++;
            $display("FAIL bp_after: got busy=%b s3=%0d want busy=0 s3=0", bus.busy, bus.rd_state);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        bus.ev_ready = 1'b1;
        do_tick();              // T+1
        n_tests++;
        if (bus.overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_quiet: got %b want 0", bus.overrun);
        end
        step();                 // T+2
        bus.tick = 1'b1;
        step();                 // T+3
        bus.tick = 1'b0;
        n_tests++;
        if (bus.overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_pulse: got %b want 1", bus.overrun);
        end
        step();                 // T+4
        n_tests++;
        if (bus.overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_single: got %b want 0", bus.overrun);
        end
        step(2);                // T+6
        n_tests++;
        if (bus.done !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_len: done got %b want 1", bus.done);
        end
        step();                 // T+7
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_end: busy got %b want 0", bus.busy);
        end
        step();                 // T+8
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_no_second: busy got %b want 0", bus.busy);
        end
    endtask

    task automatic test_thr_midstep();
        do_reset();
        bus.ev_ready = 1'b1;
        bus.rd_addr  = 2'd2;
        write_cur(2'd2, 8'd60);
        do_tick();
        step(6);
        n_tests++;
        if (bus.rd_state !== 8'd60) begin
            n_fail++;
            $display("FAIL mid_charge: got %0d want 60", bus.rd_state);
        end
        do_tick();              // T+1 neuron 0
        step(2);                // T+3 neuron 2
        bus.thr_we = 1'b1; bus.thr_data = 8'd50;
        bus.cfg_we = 1'b1; bus.cfg_addr = 2'd2; bus.cfg_data = 8'd10;
        step();                 // T+4
        bus.thr_we = 1'b0; bus.cfg_we = 1'b0;
        step();                 // T+5
        n_tests++;
        if (bus.ev_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_no_spike: ev_valid got %b want 0", bus.ev_valid);
        end
        step(2);                // T+7
        n_tests++;
        if (bus.rd_state !== 8'd113) begin
            n_fail++;
            $display("FAIL mid_old_vals: got %0d want 113", bus.rd_state);
        end
        do_tick();
        step(4);                // T+5
        n_tests++;
        if (bus.ev_valid !== 1'b1 || bus.ev_addr !== 2'd2) begin
            n_fail++;
            $display("FAIL mid_next_spike: got v=%b a=%0d want v=1 a=2", bus.ev_valid, bus.ev_addr);
        end
        step(2);
        n_tests++;
        if (bus.rd_state !== 8'd0) begin
            n_fail++;
            $display("FAIL mid_spike_reset: got %0d want 0", bus.rd_state);
        end
        do_tick();
        step(6);
        n_tests++;
        if (bus.rd_state !== 8'd10) begin
            n_fail++;
            $display("FAIL mid_new_cur: got %0d want 10", bus.rd_state);
        end
    endtask

    task automatic test_reset_emit();
        do_reset();
        bus.ev_ready = 1'b0;
        bus.thr_we = 1'b1; bus.thr_data = 8'd50;
        write_cur(2'd0, 8'd150);
        bus.thr_we = 1'b0;
        write_cur(2'd1, 8'd150);
        do_tick();
        step(6);
        do_tick();
        step(4);                // T+5, events 0 and 1 pending
        n_tests++;
        if (bus.ev_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rstemit_pre: ev_valid got %b want 1", bus.ev_valid);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_tests++;
        if ({bus.ev_valid, bus.busy, bus.done} !== 3'b000) begin
            n_fail++;
            $display("FAIL rstemit_ctrl: got %b want 000", {bus.ev_valid, bus.busy, bus.done});
        end
        for (int i = 0; i < 4; i++) begin
            bus.rd_addr = 2'(i);
            #1;
            n_tests++;
            if (bus.rd_state !== 8'd0) begin
                n_fail++;
                $display("FAIL rstemit_state%0d: got %0d want 0", i, bus.rd_state);
            end
        end
        step(3);
        n_tests++;
        if ({bus.ev_valid, bus.busy, bus.done} !== 3'b000) begin
            n_fail++;
            $display("FAIL rstemit_quiet: got %b want 000", {bus.ev_valid, bus.busy, bus.done});
        end
        // Threshold must be back at 200: a state of 150 must not spike.
        bus.ev_ready = 1'b1;
        bus.rd_addr  = 2'd0;
        write_cur(2'd0, 8'd150);
        do_tick();
        step(6);
        do_tick();
        step(4);
        n_tests++;
        if (bus.ev_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstemit_thr: ev_valid got %b want 0", bus.ev_valid);
        end
        step(2);
        n_tests++;
        if (bus.rd_state !== 8'd255) begin
            n_fail++;
            $display("FAIL rstemit_sat: got %0d want 255", bus.rd_state);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.tick = 1'b0; bus.cfg_we = 1'b0; bus.cfg_addr = 2'd0; bus.cfg_data = 8'd0;
        bus.thr_we = 1'b0; bus.thr_data = 8'd0; bus.rd_addr = 2'd0; bus.ev_ready = 1'b0;
        test_reset();
        test_saturation();
        test_no_spike();
        test_backpressure();
        test_overrun();
        test_thr_midstep();
        test_reset_emit();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
